// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: reset address, the NOP bubble value and
// the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // addi x0,x0,0 -- presented to decode whenever no live instruction is held
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter register.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_inc        : advance the PC by one word (+4, wraps modulo 2^32)
//   i_load       : load i_load_addr (takes priority over i_inc)
//   i_load_addr  : redirect target, already word aligned by the caller
//   o_pc         : current fetch PC
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = instr_fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_load,
  input  logic [31:0] i_load_addr,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: issues word requests to the I-cache over a
// req/ready handshake and keeps a single-entry instruction register for
// decode. Absorbs cache misses, downstream stalls and redirects.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   ic_req/ic_addr        : request and word address to the I-cache
//   ic_ready/ic_rdata     : cache completion and returned instruction
//   stall                 : decode cannot take Instr this cycle
//   redirect/redirect_pc  : restart fetch at redirect_pc (low bits ignored)
//   Instr/PC/PCPlus4      : registered instruction, its address, address+4
//   instr_valid           : Instr/PC hold a live instruction
//
// state | meaning
// FETCH | normal fetching at fetch_pc
// DRAIN | redirect hit an outstanding miss; waiting out the old request
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = instr_fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = instr_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid
);

  import instr_fetch_pkg::*;

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_drain_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc;
  logic         r_valid;

  logic [31:0]  w_fetch_pc;
  logic [31:0]  w_redirect_word;
  logic         w_ic_req;
  logic [31:0]  w_ic_addr;
  logic         w_fetch_xfer;

  assign w_redirect_word = redirect_pc & 32'hFFFF_FFFC;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inc       (w_fetch_xfer && !redirect),
    .i_load      (redirect),
    .i_load_addr (w_redirect_word),
    .o_pc        (w_fetch_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ic_req     = 1'b0;
    w_ic_addr    = w_fetch_pc;
    case (r_state)
      FETCH: begin
        w_ic_req = !r_valid || !stall;
        // A redirect cannot cancel a request the cache has not yet answered
        if (redirect && w_ic_req && !ic_ready) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        w_ic_req  = 1'b1;
        w_ic_addr = r_drain_addr;
        if (ic_ready) begin
          w_next_state = FETCH;
        end
      end
      default: w_next_state = FETCH;
    endcase
    // The cache shares this reset, so nothing is outstanding during it
    if (!rst_n) begin
      w_ic_req = 1'b0;
    end
  end

  assign w_fetch_xfer = (r_state == FETCH) && w_ic_req && ic_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drain_addr <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc         <= RESET_PC;
      r_valid      <= 1'b0;
    end else begin
      if (r_state == FETCH && w_next_state == DRAIN) begin
        r_drain_addr <= w_fetch_pc;
      end
      if (redirect) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end else if (w_fetch_xfer) begin
        r_instr <= ic_rdata;
        r_pc    <= w_fetch_pc;
        r_valid <= 1'b1;
      end else if (r_state == FETCH && r_valid && !stall) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
    end
  end

  assign ic_req      = w_ic_req;
  assign ic_addr     = w_ic_addr;
  assign Instr       = r_instr;
  assign PC          = r_pc;
  assign PCPlus4     = r_pc + 32'd4;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hits, miss, stall, redirects, drain, wrap
// and reset during a miss, against hand-computed expected values.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ic_req      (ic_req),
    .ic_addr     (ic_addr),
    .ic_ready    (ic_ready),
    .ic_rdata    (ic_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ic_ready = 1'b1; ic_rdata = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("req_in_reset", {31'b0, ic_req}, 32'd0);
    cyc();
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", PC, 32'h0);
    chk("rst_pcplus4", PCPlus4, 32'h4);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);

    // back-to-back hits at 0,4,8,C
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ic_rdata = 32'h1000_0000 + 32'(4 * i);
      #1;
      chk("hit_req", {31'b0, ic_req}, 32'd1);
      chk("hit_addr", ic_addr, 32'(4 * i));
      cyc();
      chk("hit_instr", Instr, 32'h1000_0000 + 32'(4 * i));
      chk("hit_pc", PC, 32'(4 * i));
      chk("hit_valid", {31'b0, instr_valid}, 32'd1);
    end

    // miss at 0x10 for 5 cycles
    ic_ready = 1'b0; ic_rdata = 32'hBAAD_F00D;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("miss_addr", ic_addr, 32'h10);
      chk("miss_req", {31'b0, ic_req}, 32'd1);
      cyc();
      chk("miss_instr", Instr, NOP);
      chk("miss_valid", {31'b0, instr_valid}, 32'd0);
    end
    ic_ready = 1'b1; ic_rdata = 32'h1000_0010;
    #1;
    chk("miss_done_addr", ic_addr, 32'h10);
    cyc();
    chk("miss_instr_done", Instr, 32'h1000_0010);
    chk("miss_pc_done", PC, 32'h10);
    chk("miss_valid_done", {31'b0, instr_valid}, 32'd1);

    // stall 3 cycles
    stall = 1'b1; ic_rdata = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {31'b0, ic_req}, 32'd0);
      cyc();
      chk("stall_instr", Instr, 32'h1000_0010);
      chk("stall_pc", PC, 32'h10);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    stall = 1'b0; ic_rdata = 32'h1000_0014;
    #1;
    chk("resume_req", {31'b0, ic_req}, 32'd1);
    chk("resume_addr", ic_addr, 32'h14);
    cyc();
    chk("resume_pc", PC, 32'h14);
    chk("resume_instr", Instr, 32'h1000_0014);

    // redirect to 0x203 during a hit at 0x18
    redirect = 1'b1; redirect_pc = 32'h203; ic_rdata = 32'hDEAD_BEEF;
    #1;
    chk("redir_hit_addr", ic_addr, 32'h18);
    cyc();
    redirect = 1'b0; ic_rdata = 32'h1000_0200;
    #1;
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_instr", Instr, NOP);
    chk("redir_addr", ic_addr, 32'h200);
    cyc();
    chk("redir_tgt_instr", Instr, 32'h1000_0200);
    chk("redir_tgt_pc", PC, 32'h200);
    chk("redir_tgt_valid", {31'b0, instr_valid}, 32'd1);

    // move to 0x20, then redirect to 0x400 while its miss is pending
    redirect = 1'b1; redirect_pc = 32'h20; ic_rdata = 32'hDEAD_0204;
    cyc();
    ic_ready = 1'b0; redirect_pc = 32'h400;
    #1;
    chk("pre_drain_addr", ic_addr, 32'h20);
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drain_req", {31'b0, ic_req}, 32'd1);
      chk("drain_addr", ic_addr, 32'h20);
      chk("drain_valid", {31'b0, instr_valid}, 32'd0);
      cyc();
    end
    ic_ready = 1'b1; ic_rdata = 32'hBAD0_BAD0;
    #1;
    chk("drain_last_addr", ic_addr, 32'h20);
    cyc();
    ic_rdata = 32'h1000_0400;
    #1;
    chk("drain_drop_valid", {31'b0, instr_valid}, 32'd0);
    chk("drain_drop_instr", Instr, NOP);
    chk("post_drain_addr", ic_addr, 32'h400);
    cyc();
    chk("post_drain_instr", Instr, 32'h1000_0400);
    chk("post_drain_pc", PC, 32'h400);

    // redirect to the top word, fetch wraps to 0
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; ic_rdata = 32'hDEAD_0404;
    cyc();
    redirect = 1'b0; ic_rdata = 32'h1FFF_FFFC;
    #1;
    chk("wrap_tgt_addr", ic_addr, 32'hFFFF_FFFC);
    cyc();
    ic_rdata = 32'h1000_0000;
    #1;
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4, 32'h0);
    chk("wrap_next_addr", ic_addr, 32'h0);
    cyc();
    chk("wrap_pc0", PC, 32'h0);
    chk("wrap_instr0", Instr, 32'h1000_0000);

    // reset in the middle of a miss at 0x4
    ic_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midmiss_req_rst", {31'b0, ic_req}, 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", {31'b0, ic_req}, 32'd1);
    chk("post_rst_addr", ic_addr, 32'h0);
    chk("post_rst_valid", {31'b0, instr_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
